ar_tx_sched: RTL
================

Name: ar_tx_sched

Overview:
- Round-robin scheduler that shares one ARINC-429 word transmitter among four requesters.
- Arbitrates pending requests and latches the winner's 8-bit label and 23-bit data.
- Issues a single-cycle start to the transmitter, then tracks the transmitter's word-busy flag.
- Inserts a programmable extra inter-word gap, counted in bit times at the selected rate, before the next grant.

Parameters:
- Fclk, 50000000, system clock frequency in Hz.
- GAP_BITS, 4, extra idle bit times inserted after each word; range 0..15.
- START_TO, 8, clk cycles allowed for tx_busy to rise after tx_st.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  scheduler enable; when low, no new grants; the word in progress completes.
- Nvel  in  2  rate select: 3=1 Mb/s, 2=100 kb/s, 1=50 kb/s, 0=12.5 kb/s. Drives tx_Nvel and the gap timing.
- req  in  4  request per source; level, held until ack.
- req_adr  in  32  labels, source i on bits [8i+7:8i].
- req_dat  in  92  data, source i on bits [23i+22:23i].
- ack  out  4  one-cycle pulse: source i's word is latched; source may drop or change req.
- tx_st  out  1  start pulse to the transmitter.
- tx_adr  out  8  latched label.
- tx_dat  out  23  latched data.
- tx_Nvel  out  2  registered copy of Nvel, updated only in IDLE.
- tx_busy  in  1  transmitter word-in-progress flag; covers 32 bits plus the 4-bit built-in gap.
- busy  out  1  high in every state except IDLE.
- cur_id  out  2  index of the last granted source.
- err  out  1  one-cycle pulse on start timeout.

Behaviour:
- Reset (async assert, sync release):
  - Outputs: ack=0, tx_st=0, tx_adr=0, tx_dat=0, tx_Nvel=0, busy=0, cur_id=0, err=0.
  - Internal: state=IDLE, rr_ptr=3 (first search starts at source 0), timers=0.
  - Reset mid-word drops tx_st immediately; the transmitter is not notified.
- Arbitration:
  - Search order starts at rr_ptr+1 (mod 4) and wraps.
  - The first source with req=1 wins; rr_ptr and cur_id take the winner's index.
- State IDLE:
  - Entry condition: en=1, tx_busy=0, and any req=1.
  - Same cycle: latch tx_adr/tx_dat from the winner's slice, latch tx_Nvel<=Nvel, pulse ack[winner] for one cycle.
  - Next state: START.
  - tx_busy=1 while in IDLE (foreign start) blocks grants.
- State START:
  - tx_st=1 for exactly one cycle; start timer cleared.
  - Next state: WAIT_BUSY.
  - Latency: req rising in IDLE to tx_st = 2 cycles (ack at cycle 1, tx_st at cycle 2).
- State WAIT_BUSY:
  - tx_busy=1: go to WAIT_DONE.
  - Otherwise the timer increments. When the timer reaches START_TO-1: pulse err, go to IDLE. The request is not retried and is not re-acked.
- State WAIT_DONE:
  - Wait for tx_busy=0.
  - GAP_BITS=0: go to IDLE.
  - Otherwise: go to GAP with bit_cnt=0 and clk_cnt=0.
- State GAP:
  - Bit time in clks: Fclk/1000000, Fclk/100000, Fclk/50000, Fclk/12500 for tx_Nvel 3/2/1/0 (50/500/1000/4000 at the default Fclk).
  - clk_cnt counts 1..bit time, then wraps and increments bit_cnt.
  - bit_cnt reaching GAP_BITS: go to IDLE.
  - Counters are 12 bits and 4 bits.
  - Extra gap in clks = GAP_BITS x bit time, ±1 cycle.
- en:
  - Sampled only in IDLE.
  - en falling in any other state does not abort the word or the gap.
- Request changes:
  - req dropped before ack: no grant.
  - req_adr/req_dat changing after ack do not affect the latched word.
  - Simultaneous requests: one grant per word, strictly rotating.
  - A requester that holds req continuously gets every 4th slot when all four are active.
- Nvel changing mid-word has no effect until the next IDLE.

Test Plan:
- Single request: req=0001, adr0=8'hA5, dat0=23'h12345, Nvel=3, tx model busy for 36 µs.
  - ack=0001 for 1 cycle, then tx_st 1 cycle later with tx_adr=A5, tx_dat=12345.
  - Next start is no sooner than 36 µs plus 4x50 clks after tx_busy falls.
- Round robin: req=1111 held, 8 words.
  - Grant order 0,1,2,3,0,1,2,3.
  - ack pulses one-hot; cur_id follows the grant order.
- Start timeout: tx model never raises busy.
  - err pulses exactly START_TO cycles after WAIT_BUSY entry; state returns to IDLE; busy=0.
- Gap at 12.5 kb/s: Nvel=0, GAP_BITS=4.
  - tx_busy fall to next tx_st = 16000±2 clks.
- en dropped mid-word: en=0 during WAIT_DONE with req=0011.
  - Current word completes; no further ack until en=1.
- Async reset: rst_n low during GAP or while tx_st is asserted.
  - All outputs 0 immediately.
  - After release, first grant goes to source 0 when req=1111.

Source files
------------

// File: rtl/ar_tx_sched_if.sv
// Requester, transmitter and status signals of the ARINC-429 transmit scheduler.
// The scheduler takes the slave view; the environment driving it takes master.
interface ar_tx_sched_if;
  logic        en;
  logic [1:0]  Nvel;
  logic [3:0]  req;
  logic [31:0] req_adr;
  logic [91:0] req_dat;
  logic [3:0]  ack;
  logic        tx_st;
  logic [7:0]  tx_adr;
  logic [22:0] tx_dat;
  logic [1:0]  tx_Nvel;
  logic        tx_busy;
  logic        busy;
  logic [1:0]  cur_id;
  logic        err;

  modport slave (
    input  en, Nvel, req, req_adr, req_dat, tx_busy,
    output ack, tx_st, tx_adr, tx_dat, tx_Nvel, busy, cur_id, err
  );

  modport master (
    output en, Nvel, req, req_adr, req_dat, tx_busy,
    input  ack, tx_st, tx_adr, tx_dat, tx_Nvel, busy, cur_id, err
  );
endinterface

// File: rtl/ar_tx_sched.sv
// Round-robin scheduler sharing one ARINC-429 word transmitter among four sources,
// with start-timeout detection and a programmable inter-word gap in bit times.
module ar_tx_sched #(
  parameter int Fclk     = 50000000,
  parameter int GAP_BITS = 4,
  parameter int START_TO = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  ar_tx_sched_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  localparam logic [11:0] BT_1M   = 12'(Fclk / 1000000);
  localparam logic [11:0] BT_100K = 12'(Fclk / 100000);
  localparam logic [11:0] BT_50K  = 12'(Fclk / 50000);
  localparam logic [11:0] BT_12K5 = 12'(Fclk / 12500);
  localparam logic [7:0]  TO_LAST  = 8'(START_TO - 1);
  localparam logic [3:0]  GAP_LAST = 4'(GAP_BITS - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_rr_ptr;
  logic [1:0]  r_cur_id;
  logic [3:0]  r_ack;
  logic        r_tx_st;
  logic [7:0]  r_tx_adr;
  logic [22:0] r_tx_dat;
  logic [1:0]  r_tx_nvel;
  logic        r_err;
  logic [7:0]  r_to_cnt;
  logic [11:0] r_clk_cnt;
  logic [3:0]  r_bit_cnt;

  logic        w_win_vld;
  logic [1:0]  w_win_id;
  logic        w_grant;
  logic        w_err_nxt;
  logic        w_to_expire;
  logic [11:0] w_bt;
  logic        w_gap_wrap;
  logic        w_gap_done;

  // Search starts one past the last winner, so a held request waits at most three words.
  // NOTE: every combinational output gets a default before any branch; a path that
  // leaves one unassigned infers a latch.
  always_comb begin
    w_win_vld = 1'b0;
    w_win_id  = r_rr_ptr;
    for (int i = 1; i <= 4; i++) begin
      if (!w_win_vld && bus.req[r_rr_ptr + 2'(i)]) begin
        w_win_vld = 1'b1;
        w_win_id  = r_rr_ptr + 2'(i);
      end
    end
  end

  // A word already running on the transmitter (ours or foreign) blocks grants.
  assign w_grant = (r_state == S_IDLE) && bus.en && !bus.tx_busy && w_win_vld;

  always_comb begin
    w_bt = BT_12K5;
    case (r_tx_nvel)
      2'd3:    w_bt = BT_1M;
      2'd2:    w_bt = BT_100K;
      2'd1:    w_bt = BT_50K;
      default: w_bt = BT_12K5;
    endcase
  end

  assign w_to_expire = (r_to_cnt == TO_LAST);
  assign w_gap_wrap  = (r_clk_cnt == w_bt - 12'd1);
  // The last gap bit ends one clock early: the IDLE grant cycle is its final clock.
  assign w_gap_done  = (r_bit_cnt == GAP_LAST) && (r_clk_cnt == w_bt - 12'd2);

  always_comb begin
    w_state_nxt = r_state;
    w_err_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_grant) w_state_nxt = S_START;
      end
      S_START: begin
        w_state_nxt = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (bus.tx_busy) begin
          w_state_nxt = S_WAIT_DONE;
        end else if (w_to_expire) begin
          w_state_nxt = S_IDLE;
          w_err_nxt   = 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (!bus.tx_busy) w_state_nxt = (GAP_BITS == 0) ? S_IDLE : S_GAP;
      end
      S_GAP: begin
        if (w_gap_done) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Grant capture: the label/data/rate snapshot is taken on the ack cycle only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr  <= 2'd3;
      r_cur_id  <= 2'd0;
      r_ack     <= 4'd0;
      r_tx_st   <= 1'b0;
      r_tx_adr  <= 8'd0;
      r_tx_dat  <= 23'd0;
      r_tx_nvel <= 2'd0;
      r_err     <= 1'b0;
    end else begin
      r_ack   <= 4'd0;
      r_tx_st <= (r_state == S_START);
      r_err   <= w_err_nxt;
      if (w_grant) begin
        r_ack     <= 4'b0001 << w_win_id;
        r_rr_ptr  <= w_win_id;
        r_cur_id  <= w_win_id;
        r_tx_adr  <= bus.req_adr[8*w_win_id +: 8];
        r_tx_dat  <= bus.req_dat[23*w_win_id +: 23];
        r_tx_nvel <= bus.Nvel;
      end
    end
  end

  // Start timeout and gap counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt  <= 8'd0;
      r_clk_cnt <= 12'd0;
      r_bit_cnt <= 4'd0;
    end else begin
      case (r_state)
        S_START: begin
          r_to_cnt <= 8'd0;
        end
        S_WAIT_BUSY: begin
          if (!bus.tx_busy && !w_to_expire) r_to_cnt <= r_to_cnt + 8'd1;
        end
        S_WAIT_DONE: begin
          r_clk_cnt <= 12'd0;
          r_bit_cnt <= 4'd0;
        end
        S_GAP: begin
          if (w_gap_wrap) begin
            r_clk_cnt <= 12'd0;
            r_bit_cnt <= r_bit_cnt + 4'd1;
          end else begin
            r_clk_cnt <= r_clk_cnt + 12'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ack     = r_ack;
  assign bus.tx_st   = r_tx_st;
  assign bus.tx_adr  = r_tx_adr;
  assign bus.tx_dat  = r_tx_dat;
  assign bus.tx_Nvel = r_tx_nvel;
  assign bus.busy    = (r_state != S_IDLE);
  assign bus.cur_id  = r_cur_id;
  assign bus.err     = r_err;

endmodule
